// File: rtl/coeff_seq_ctrl.sv
// coeff_seq_ctrl: round-robin coefficient address sequencer.
// Each channel owns a table pointer. Requesting channels are arbitrated into a
// single registered address stage (valid/ready) toward the coefficient memory.
// Optional feature macro: COEFF_SEQ_STATS_EN adds a saturating handshake counter.
module coeff_seq_ctrl #(
    parameter int ADDR_LINES = 4,
    parameter int CHANNELS   = 4,
    parameter int WRAP_MODE  = 0,
    localparam int CH_BITS   = $clog2(CHANNELS),
    localparam int DEPTH     = 1 << ADDR_LINES
) (
    input  logic                             clkn_i,
    input  logic                             rst_i,
    input  logic [CHANNELS-1:0]              redo_i,
    input  logic [CHANNELS-1:0]              rd_req_i,
    input  logic [DEPTH-1:0]                 adv_mask_i,
    input  logic                             mem_ready_i,
    output logic                             mem_valid_o,
    output logic [CH_BITS+ADDR_LINES-1:0]    mem_addr_o,
    output logic [CHANNELS-1:0]              rd_ack_o,
    output logic [CHANNELS*ADDR_LINES-1:0]   ptr_o,
    output logic [CHANNELS-1:0]              last_o
`ifdef COEFF_SEQ_STATS_EN
    ,
    output logic [15:0]                      stat_cnt_o
`endif
);

    localparam logic [ADDR_LINES-1:0] TOP = '1;

    logic [CHANNELS-1:0][ADDR_LINES-1:0] ptr, ptr_nxt;
    logic                                vld;
    logic [CH_BITS-1:0]                  stage_ch;
    logic [ADDR_LINES-1:0]               stage_ptr;
    logic [CH_BITS-1:0]                  rr_start;
    logic [CHANNELS-1:0]                 cand;
    logic [CHANNELS-1:0]                 ack_nxt;
    logic                                found;
    logic [CH_BITS-1:0]                  sel;
    logic                                hs;
    logic                                load;

    assign hs   = vld & mem_ready_i;
    assign load = ~vld | mem_ready_i;
    // A channel being cleared this cycle is not eligible for service
    assign cand = rd_req_i & ~redo_i;

    // Next pointer per channel: clear wins over advance; advance gated by the entry mask
    always_comb begin
        ptr_nxt = ptr;
        for (int c = 0; c < CHANNELS; c++) begin
            if (redo_i[c]) begin
                ptr_nxt[c] = '0;
            end else if (hs && stage_ch == CH_BITS'(c) && adv_mask_i[ptr[c]]) begin
                if (ptr[c] == TOP)
                    ptr_nxt[c] = (WRAP_MODE != 0) ? '0 : TOP;
                else
                    ptr_nxt[c] = ptr[c] + 1'b1;
            end
        end
    end

    // Round-robin pick: first candidate at or after rr_start, wrapping around
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = int'(rr_start) + i;
            if (idx >= CHANNELS)
                idx = idx - CHANNELS;
            if (!found && cand[idx]) begin
                found = 1'b1;
                sel   = CH_BITS'(idx);
            end
        end
    end

    // One-hot acknowledge for the channel completing a handshake
    always_comb begin
        ack_nxt = '0;
        if (hs)
            ack_nxt[stage_ch] = 1'b1;
    end

    // Pointers, output stage and arbitration state
    always_ff @(posedge clkn_i) begin
        if (rst_i) begin
            ptr       <= '0;
            vld       <= 1'b0;
            stage_ch  <= '0;
            stage_ptr <= '0;
            rr_start  <= '0;
            rd_ack_o  <= '0;
            last_o    <= '0;
        end else begin
            ptr      <= ptr_nxt;
            rd_ack_o <= ack_nxt;
            for (int c = 0; c < CHANNELS; c++)
                last_o[c] <= (ptr_nxt[c] == TOP);
            if (load) begin
                vld <= found;
                if (found) begin
                    // Post-update pointer so a re-served channel sees its advance
                    stage_ch  <= sel;
                    stage_ptr <= ptr_nxt[sel];
                    rr_start  <= (sel == CH_BITS'(CHANNELS - 1)) ? '0 : sel + 1'b1;
                end
            end
        end
    end

    assign mem_valid_o = vld;
    assign mem_addr_o  = {stage_ch, stage_ptr};
    assign ptr_o       = ptr;

`ifdef COEFF_SEQ_STATS_EN
    // Saturating handshake counter; only reset clears it
    always_ff @(posedge clkn_i) begin
        if (rst_i)
            stat_cnt_o <= '0;
        else if (hs && stat_cnt_o != 16'hFFFF)
            stat_cnt_o <= stat_cnt_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_coeff_seq_ctrl.sv
// Directed bench for coeff_seq_ctrl (ADDR_LINES=4, CHANNELS=4).
// Two instances share stimulus: saturating (WRAP_MODE=0) and wrapping (WRAP_MODE=1).
module tb_coeff_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  redo = '0;
    logic [3:0]  req = '0;
    logic [15:0] adv = '1;
    logic        ready = 1'b0;

    logic        mvld, mvld_w;
    logic [5:0]  maddr, maddr_w;
    logic [3:0]  ack, ack_w;
    logic [15:0] ptro, ptro_w;
    logic [3:0]  last, last_w;
`ifdef COEFF_SEQ_STATS_EN
    logic [15:0] stat, stat_w;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    coeff_seq_ctrl #(.ADDR_LINES(4), .CHANNELS(4), .WRAP_MODE(0)) dut (
        .clkn_i(clk), .rst_i(rst), .redo_i(redo), .rd_req_i(req),
        .adv_mask_i(adv), .mem_ready_i(ready), .mem_valid_o(mvld),
        .mem_addr_o(maddr), .rd_ack_o(ack), .ptr_o(ptro), .last_o(last)
`ifdef COEFF_SEQ_STATS_EN
        , .stat_cnt_o(stat)
`endif
    );

    coeff_seq_ctrl #(.ADDR_LINES(4), .CHANNELS(4), .WRAP_MODE(1)) dut_w (
        .clkn_i(clk), .rst_i(rst), .redo_i(redo), .rd_req_i(req),
        .adv_mask_i(adv), .mem_ready_i(ready), .mem_valid_o(mvld_w),
        .mem_addr_o(maddr_w), .rd_ack_o(ack_w), .ptr_o(ptro_w), .last_o(last_w)
`ifdef COEFF_SEQ_STATS_EN
        , .stat_cnt_o(stat_w)
`endif
    );

    task tick;
        @(posedge clk);
        #1;
    endtask

    task do_reset;
        rst = 1'b1; redo = '0; req = '0; ready = 1'b0; adv = '1;
        tick; tick;
        rst = 1'b0;
    endtask

    task test_reset;
        do_reset;
        checks++; if (mvld !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b want 0", mvld); end
        checks++; if (maddr !== 6'd0)  begin errors++; $display("FAIL reset_addr got %0d want 0", maddr); end
        checks++; if (ack !== 4'd0)    begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
        checks++; if (ptro !== 16'd0)  begin errors++; $display("FAIL reset_ptr got %h want 0000", ptro); end
        checks++; if (last !== 4'd0)   begin errors++; $display("FAIL reset_last got %b want 0000", last); end
    endtask

    task test_round_robin;
        logic [5:0] exp_a [6];
        logic [3:0] exp_k [6];
        exp_a = '{6'd0, 6'd16, 6'd32, 6'd48, 6'd1, 6'd17};
        exp_k = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset;
        req = 4'b1111; ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick;
            checks++; if (mvld !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %b want 1", k, mvld); end
            checks++; if (maddr !== exp_a[k]) begin errors++; $display("FAIL rr_addr[%0d] got %0d want %0d", k, maddr, exp_a[k]); end
            checks++; if (ack !== exp_k[k]) begin errors++; $display("FAIL rr_ack[%0d] got %b want %b", k, ack, exp_k[k]); end
            if (k == 4) begin
                checks++; if (ptro !== 16'h1111) begin errors++; $display("FAIL rr_ptrs got %h want 1111", ptro); end
            end
        end
        req = '0;
        tick;
        checks++; if (mvld !== 1'b0) begin errors++; $display("FAIL rr_drain got %b want 0", mvld); end
    endtask

    task test_stall;
        do_reset;
        req = 4'b0010; ready = 1'b0;
        tick;
        req = '0;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if (mvld !== 1'b1 || maddr !== 6'd16) begin errors++; $display("FAIL stall_hold[%0d] got v=%b a=%0d want v=1 a=16", k, mvld, maddr); end
            checks++; if (ack !== 4'd0) begin errors++; $display("FAIL stall_ack[%0d] got %b want 0000", k, ack); end
        end
        ready = 1'b1;
        tick;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL stall_ack_pulse got %b want 0010", ack); end
        checks++; if (mvld !== 1'b0) begin errors++; $display("FAIL stall_empty got %b want 0", mvld); end
        checks++; if (ptro !== 16'h0010) begin errors++; $display("FAIL stall_ptr got %h want 0010", ptro); end
        tick;
        checks++; if (ack !== 4'd0) begin errors++; $display("FAIL stall_ack_single got %b want 0000", ack); end
    endtask

    task test_wrap;
        do_reset;
        req = 4'b0001; ready = 1'b1;
        for (int k = 0; k < 16; k++) tick;
        checks++; if (ptro[3:0] !== 4'd15 || last[0] !== 1'b1) begin errors++; $display("FAIL top_sat got p=%0d l=%b want p=15 l=1", ptro[3:0], last[0]); end
        checks++; if (ptro_w[3:0] !== 4'd15 || last_w[0] !== 1'b1) begin errors++; $display("FAIL top_wrap got p=%0d l=%b want p=15 l=1", ptro_w[3:0], last_w[0]); end
        tick;
        checks++; if (ptro[3:0] !== 4'd15 || last[0] !== 1'b1) begin errors++; $display("FAIL sat_hold got p=%0d l=%b want p=15 l=1", ptro[3:0], last[0]); end
        checks++; if (maddr !== 6'd15) begin errors++; $display("FAIL sat_addr got %0d want 15", maddr); end
        checks++; if (ptro_w[3:0] !== 4'd0 || last_w[0] !== 1'b0) begin errors++; $display("FAIL wrap_zero got p=%0d l=%b want p=0 l=0", ptro_w[3:0], last_w[0]); end
        checks++; if (maddr_w !== 6'd0) begin errors++; $display("FAIL wrap_addr got %0d want 0", maddr_w); end
        req = '0;
        tick;
    endtask

    task test_adv_mask;
        do_reset;
        req = 4'b0100; ready = 1'b1;
        for (int k = 0; k < 6; k++) tick;
        checks++; if (ptro !== 16'h0500) begin errors++; $display("FAIL mask_setup got %h want 0500", ptro); end
        adv[5] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if (ptro !== 16'h0500) begin errors++; $display("FAIL mask_hold[%0d] got %h want 0500", k, ptro); end
            checks++; if (maddr !== 6'd37 || ack !== 4'b0100) begin errors++; $display("FAIL mask_hs[%0d] got a=%0d k=%b want a=37 k=0100", k, maddr, ack); end
        end
        req = '0;
        tick;
    endtask

    task test_redo;
        do_reset;
        req = 4'b0001; ready = 1'b1;
        tick; tick; tick;
        checks++; if (maddr !== 6'd2 || ptro !== 16'h0002) begin errors++; $display("FAIL redo_setup got a=%0d p=%h want a=2 p=0002", maddr, ptro); end
        redo = 4'b0001;
        tick;
        checks++; if (ptro !== 16'h0000) begin errors++; $display("FAIL redo_clear got %h want 0000", ptro); end
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL redo_ack got %b want 0001", ack); end
        checks++; if (mvld !== 1'b0) begin errors++; $display("FAIL redo_noload got %b want 0", mvld); end
        redo = '0; req = '0;
        // reset while a stalled transaction is waiting
        req = 4'b0010; ready = 1'b0;
        tick;
        req = '0;
        tick;
        checks++; if (mvld !== 1'b1) begin errors++; $display("FAIL rst_stall_setup got %b want 1", mvld); end
        rst = 1'b1;
        tick;
        checks++; if (mvld !== 1'b0 || ack !== 4'd0) begin errors++; $display("FAIL rst_drop got v=%b k=%b want v=0 k=0000", mvld, ack); end
        rst = 1'b0; ready = 1'b1;
        tick;
        checks++; if (mvld !== 1'b0 || ack !== 4'd0) begin errors++; $display("FAIL rst_noack got v=%b k=%b want v=0 k=0000", mvld, ack); end
    endtask

`ifdef COEFF_SEQ_STATS_EN
    task test_stats;
        do_reset;
        checks++; if (stat !== 16'd0) begin errors++; $display("FAIL stat_reset got %h want 0000", stat); end
        req = 4'b1111; ready = 1'b1;
        for (int k = 0; k < 70002; k++) tick;
        checks++; if (stat !== 16'hFFFF) begin errors++; $display("FAIL stat_sat got %h want FFFF", stat); end
        redo = 4'b1111;
        tick;
        checks++; if (stat !== 16'hFFFF) begin errors++; $display("FAIL stat_redo got %h want FFFF", stat); end
        redo = '0; req = '0;
    endtask
`endif

    initial begin
        test_reset;
        test_round_robin;
        test_stall;
        test_wrap;
        test_adv_mask;
        test_redo;
`ifdef COEFF_SEQ_STATS_EN
        test_stats;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
